// File: rtl/pp_extend_accumulator.sv
// Partial-product sign/zero extension, weighted shift and accumulation.
// Beats accumulate in ACC; the completed sum is held in DONE until the consumer accepts it.
module pp_extend_accumulator #(
  parameter int PP_W    = 16,
  parameter int OUT_W   = 32,
  parameter int SHIFT_W = 5,
  parameter int MAX_PP  = 6
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clear_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [PP_W-1:0]    pp_i,
  input  logic [SHIFT_W-1:0] shift_i,
  input  logic               signed_i,
  input  logic               last_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [OUT_W-1:0]   sum_o,
  output logic               err_o,
  output logic               dbg_state_o
);

  // Handshakes: a beat transfers on a rising edge where in_valid_i && in_ready_o;
  // a result transfers where out_valid_o && out_ready_i. Both ready/valid outputs
  // come straight from the state register, so neither depends on the other side.

  localparam int CNT_W = $clog2(MAX_PP + 1);

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  state_t           state;
  logic [OUT_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             err;

  logic [OUT_W-1:0] ext;
  logic [OUT_W-1:0] term;
  logic             cnt_full;

  always_comb begin
    ext      = '0;
    term     = '0;
    cnt_full = 1'b0;
    ext = signed_i ? OUT_W'($signed(pp_i)) : OUT_W'(pp_i);
    // Shifts at or beyond the output width push every bit out.
    if (int'(shift_i) < OUT_W) begin
      term = ext << shift_i;
    end
    cnt_full = (int'(cnt) + 1 == MAX_PP);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ST_ACC;
      acc   <= '0;
      cnt   <= '0;
      err   <= 1'b0;
    end else if (clear_i) begin
      state <= ST_ACC;
      acc   <= '0;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        ST_ACC: begin
          if (in_valid_i) begin
            acc <= acc + term;
            cnt <= cnt + 1'b1;
            if (last_i || cnt_full) begin
              state <= ST_DONE;
              err   <= !last_i;
            end
          end
        end
        ST_DONE: begin
          if (out_ready_i) begin
            state <= ST_ACC;
            acc   <= '0;
            cnt   <= '0;
            err   <= 1'b0;
          end
        end
        default: state <= ST_ACC;
      endcase
    end
  end

  assign in_ready_o  = (state == ST_ACC);
  assign out_valid_o = (state == ST_DONE);
  assign sum_o       = acc;
  assign err_o       = err;
  assign dbg_state_o = state;

endmodule

// File: doc/pp_extend_accumulator.md
# pp_extend_accumulator

Parametrised partial-product sign-extension and accumulation unit for the configurable multiplier. It accepts a stream of narrow partial products, one per handshake beat. Each beat is sign- or zero-extended to the output width, shifted to its weight and summed into a running accumulator. A completed sum is presented on a valid/ready output port. It replaces fixed-shift, fixed-count extension logic so that any operand split (8x8, 16x16, mixed signedness) can share one accumulation path.

## Interface
- PP_W, 16, partial-product width
- OUT_W, 32, extended/accumulated width; must be ≥ PP_W
- SHIFT_W, 5, width of the per-beat shift amount
- MAX_PP, 6, maximum beats per job before forced completion
- clk_i  input  1  clock; all state changes on its rising edge
- rst_i  input  1  reset; asynchronous, active-high
- clear_i  input  1  synchronous abort; discards the job in progress
- in_valid_i  input  1  beat valid
- in_ready_o  output  1  beat accepted when in_valid_i && in_ready_o
- pp_i  input  PP_W  partial product
- shift_i  input  SHIFT_W  left-shift (weight) applied after extension
- signed_i  input  1  1: sign-extend from pp_i[PP_W-1]; 0: zero-extend
- last_i  input  1  final beat of the job
- out_valid_o  output  1  sum_o valid
- out_ready_i  input  1  consumer accepts the sum
- sum_o  output  OUT_W  accumulated result
- err_o  output  1  job was force-completed at MAX_PP without last_i; qualified by out_valid_o

## Operation
- Two states:
  - ACC: accumulating. in_ready_o=1, out_valid_o=0.
  - DONE: holding the result. in_ready_o=0, out_valid_o=1.
- Beat accepted in ACC:
  - ext = signed_i ? sign-extend(pp_i) : zero-extend(pp_i), to OUT_W bits.
  - term = (ext << shift_i) truncated to OUT_W. If shift_i ≥ OUT_W, term = 0.
  - acc ← acc + term, modulo 2^OUT_W. No saturation and no overflow flag.
  - beat count cnt ← cnt+1.
- Transition ACC→DONE when the accepted beat has last_i=1. err ← 0.
- Transition ACC→DONE when the accepted beat is beat number MAX_PP and last_i=0. err ← 1.
  - Any further beats belonging to that job are treated as a new job. The upstream is responsible for this.
- In DONE:
  - sum_o = acc and err_o = err, both held stable until the handshake completes.
  - On out_valid_o && out_ready_i: acc ← 0, cnt ← 0, err ← 0, state → ACC.
- clear_i=1 (any state): acc ← 0, cnt ← 0, err ← 0, state → ACC.
  - Any beat presented in that cycle is dropped.
  - A pending DONE result is discarded.
  - clear_i has priority over every handshake.
- sum_o = acc in every state. Consumers sample it only while out_valid_o=1.

## Timing
- Reset values: state=ACC, acc=0, cnt=0, err=0.
  - Therefore in_ready_o=1, out_valid_o=0, sum_o=0, err_o=0.
- Reset mid-job abandons all state immediately, asynchronously.
- Throughput: one beat per cycle while in ACC.
- Latency: out_valid_o rises the cycle after the last beat is accepted. sum_o includes that beat.
- Turnaround:
  - in_ready_o returns to 1 the cycle after the output handshake.
  - Minimum one bubble between jobs. No beat is accepted in the same cycle as an output handshake.
- Backpressure: out_valid_o, sum_o and err_o are held for an unbounded time while out_ready_i=0.
- in_ready_o depends only on state. There is no combinational path from in_valid_i or out_ready_i.
- Single-beat job (last_i on the first beat) is legal: sum = term of that beat.

## Test plan
- Reset, then one beat pp_i=0x8000, signed_i=1, shift_i=0, last_i=1, out_ready_i=1.
  - Required: out_valid_o=1 next cycle, sum_o=0xFFFF8000, err_o=0, in_ready_o=1 the cycle after.
- One beat pp_i=0x8000, signed_i=0, shift_i=16, last_i=1 → sum_o=0x80000000.
- Second case: pp_i=0xFFFF, shift_i=31, signed_i=1 → sum_o=0x80000000.
- Four back-to-back signed beats:
  - Beats: (0x0001, sh16), (0xFFFF, sh8), (0x0002, sh8), (0x0003, sh0, last).
  - Required: sum_o=0x00010103.
- Repeat the previous job with out_ready_i=0 for 3 cycles.
  - Required: sum_o and out_valid_o stable, in_ready_o=0 throughout, in_valid_i ignored.
  - Required: in_ready_o=1 the cycle after out_ready_i rises.
- Six unsigned beats of 0x0001, shift 0, last_i=0 → DONE with sum_o=0x00000006, err_o=1.
- Error recovery: a following single-beat job of 0x0005 unsigned, last_i=1 → sum_o=0x00000005, err_o=0.
- Abort and reset:
  - Two beats, then clear_i=1 → next job of 0x0007 unsigned, last_i=1 gives sum_o=0x00000007.
  - rst_i asserted mid-job, between clock edges → all outputs return to their reset values immediately.
